// File: rtl/operand_mux_pipe_if.sv
// Handshake bundle for operand_mux_pipe: upstream operand/select beat in,
// selected operand with error flag out, plus the bad-select counter.
interface operand_mux_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic [CNT_W-1:0]        err_count;

  modport master (
    output in_valid, sel, in_bus, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err, err_count
  );

  modport slave (
    input  in_valid, sel, in_bus, out_ready,
    output in_ready, out_valid, out_data, out_sel_err, err_count
  );
endinterface

// File: rtl/operand_mux_pipe.sv
// N-way operand selector for the ALU datapath. Registered output stage
// with a one-entry skid so in_ready never depends combinationally on out_ready.
module operand_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst,
  operand_mux_pipe_if.slave bus
);

  // Returns {err, data}; an out-of-range select yields zero data with err set.
  function automatic logic [WIDTH:0] pick_operand(
    input logic [SEL_W-1:0]        s,
    input logic [NUM_IN*WIDTH-1:0] ops
  );
    logic [WIDTH:0] res;
    res = {1'b1, {WIDTH{1'b0}}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (32'(s) == 32'(k)) begin
        res = {1'b0, ops[k*WIDTH +: WIDTH]};
      end
    end
    return res;
  endfunction

  logic             accept_s;
  logic             emit_s;
  logic [WIDTH-1:0] pick_data_s;
  logic             pick_err_s;

  logic             main_valid_r;
  logic [WIDTH-1:0] main_data_r;
  logic             main_err_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             skid_err_r;
  logic [CNT_W-1:0] err_count_r;

  // Operand selection and handshake qualifiers.
  always_comb begin
    {pick_err_s, pick_data_s} = pick_operand(bus.sel, bus.in_bus);
    accept_s = bus.in_valid & ~skid_valid_r;
    emit_s   = main_valid_r & bus.out_ready;
  end

  // Main/skid storage: main drives the outputs, skid absorbs a beat while main stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {WIDTH{1'b0}};
      main_err_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {WIDTH{1'b0}};
      skid_err_r   <= 1'b0;
    end else if (!main_valid_r || (emit_s && !skid_valid_r)) begin
      if (accept_s) begin
        main_valid_r <= 1'b1;
        main_data_r  <= pick_data_s;
        main_err_r   <= pick_err_s;
      end else if (emit_s) begin
        main_valid_r <= 1'b0;
      end
    end else if (emit_s) begin
      // Skid is full here, so in_ready is low and no new beat can arrive.
      main_data_r  <= skid_data_r;
      main_err_r   <= skid_err_r;
      skid_valid_r <= 1'b0;
    end else if (accept_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= pick_data_s;
      skid_err_r   <= pick_err_s;
    end
  end

  // Saturating count of accepted beats carrying an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && pick_err_s && (err_count_r != {CNT_W{1'b1}})) begin
      err_count_r <= err_count_r + CNT_W'(1);
    end
  end

  assign bus.in_ready    = ~skid_valid_r;
  assign bus.out_valid   = main_valid_r;
  assign bus.out_data    = main_data_r;
  assign bus.out_sel_err = main_err_r;
  assign bus.err_count   = err_count_r;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Bench for operand_mux_pipe: three configurations (3-way default, 5-way 16-bit,
// 4-way fully decoded) checked each cycle against a FIFO-queue reference model.
module tb_operand_mux_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_mux_pipe_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CNT_W(8)) if0 ();
  operand_mux_pipe_if #(.WIDTH(16), .NUM_IN(5), .SEL_W(3), .CNT_W(8)) if1 ();
  operand_mux_pipe_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .CNT_W(8)) if2 ();

  operand_mux_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .CNT_W(8)) u_def  (.clk(clk), .rst(rst), .bus(if0));
  operand_mux_pipe #(.WIDTH(16), .NUM_IN(5), .SEL_W(3), .CNT_W(8)) u_five (.clk(clk), .rst(rst), .bus(if1));
  operand_mux_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .CNT_W(8)) u_four (.clk(clk), .rst(rst), .bus(if2));

  // Stimulus per DUT (index 0 = default, 1 = five-way, 2 = four-way).
  logic        inv   [3];
  logic        ordy  [3];
  logic [2:0]  selv  [3];
  logic [31:0] opnd  [3][5];

  logic        irdy  [3];
  logic        ov    [3];
  logic        oerr  [3];
  logic [31:0] odata [3];
  logic [7:0]  ecnt  [3];

  assign if0.in_valid  = inv[0];
  assign if0.out_ready = ordy[0];
  assign if0.sel       = selv[0][1:0];
  assign if0.in_bus    = {opnd[0][2], opnd[0][1], opnd[0][0]};
  assign if1.in_valid  = inv[1];
  assign if1.out_ready = ordy[1];
  assign if1.sel       = selv[1];
  assign if1.in_bus    = {opnd[1][4][15:0], opnd[1][3][15:0], opnd[1][2][15:0],
                          opnd[1][1][15:0], opnd[1][0][15:0]};
  assign if2.in_valid  = inv[2];
  assign if2.out_ready = ordy[2];
  assign if2.sel       = selv[2][1:0];
  assign if2.in_bus    = {opnd[2][3], opnd[2][2], opnd[2][1], opnd[2][0]};

  assign irdy[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign oerr[0] = if0.out_sel_err;
  assign irdy[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign oerr[1] = if1.out_sel_err;
  assign irdy[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign oerr[2] = if2.out_sel_err;
  assign odata[0] = if0.out_data;
  assign odata[1] = {16'h0000, if1.out_data};
  assign odata[2] = if2.out_data;
  assign ecnt[0] = if0.err_count;
  assign ecnt[1] = if1.err_count;
  assign ecnt[2] = if2.err_count;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: each DUT is a FIFO of at most two held beats {err, data}.
  int          ni    [3] = '{3, 5, 4};
  int          smask [3] = '{3, 7, 3};
  logic [31:0] wmask [3] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [32:0] mq    [3][$];
  int          mcnt  [3];
  int          nacc  [3];
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        mq[d].delete();
        mcnt[d] = 0;
      end
      model_live = 1'b1;
    end else begin
      for (int d = 0; d < 3; d++) begin
        bit          acc;
        bit          em;
        int          s;
        logic [32:0] beat;
        acc = inv[d] && (mq[d].size() < 2);
        em  = (mq[d].size() > 0) && ordy[d];
        s   = int'(selv[d]) & smask[d];
        beat = (s < ni[d]) ? {1'b0, opnd[d][s] & wmask[d]} : {1'b1, 32'h0};
        if (em) void'(mq[d].pop_front());
        if (acc) begin
          mq[d].push_back(beat);
          nacc[d]++;
          if (beat[32] && mcnt[d] < 255) mcnt[d]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("d%0d_in_ready", d), 32'(irdy[d]), 32'(mq[d].size() < 2));
        check($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(mq[d].size() > 0));
        if (mq[d].size() > 0) begin
          check($sformatf("d%0d_out_data", d), odata[d], mq[d][0][31:0]);
          check($sformatf("d%0d_out_sel_err", d), 32'(oerr[d]), 32'(mq[d][0][32]));
        end
        check($sformatf("d%0d_err_count", d), 32'(ecnt[d]), 32'(mcnt[d]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    for (int d = 0; d < 3; d++) begin
      inv[d] = 1'b0; ordy[d] = 1'b1; selv[d] = 3'd0; nacc[d] = 0; mcnt[d] = 0;
      for (int k = 0; k < 5; k++) opnd[d][k] = 32'h0;
    end
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", odata[0], 32'h0);
    check("rst_err_count", 32'(ecnt[0]), 32'd0);
    check("rst_in_ready", 32'(irdy[0]), 32'd1);

    // A, B, C back to back with out_ready high.
    opnd[0][0] = 32'hAAAA_0001; opnd[0][1] = 32'hBBBB_0002; opnd[0][2] = 32'hCCCC_0003;
    step(); inv[0] = 1'b1; selv[0] = 3'd0;
    step(); selv[0] = 3'd1;
    @(negedge clk); check("seq_a", odata[0], 32'hAAAA_0001);
    step(); selv[0] = 3'd2;
    @(negedge clk); check("seq_b", odata[0], 32'hBBBB_0002);
    step(); inv[0] = 1'b0;
    @(negedge clk); check("seq_c", odata[0], 32'hCCCC_0003);
    check("seq_c_err", 32'(oerr[0]), 32'd0);

    // Bad select, then saturation of the counter.
    step(); inv[0] = 1'b1; selv[0] = 3'd3;
    step(); inv[0] = 1'b0;
    @(negedge clk);
    check("bad_data", odata[0], 32'h0);
    check("bad_err", 32'(oerr[0]), 32'd1);
    check("bad_cnt", 32'(ecnt[0]), 32'd1);
    step(); inv[0] = 1'b1;
    repeat (300) step();
    inv[0] = 1'b0;
    step();
    @(negedge clk); check("cnt_saturated", 32'(ecnt[0]), 32'd255);

    // Backpressure: X held, Y in skid, Z blocked, then drained in order.
    opnd[0][0] = 32'h0000_00A1; opnd[0][1] = 32'h0000_00B2; opnd[0][2] = 32'h0000_00C3;
    ordy[0] = 1'b0; inv[0] = 1'b1; selv[0] = 3'd0;
    step(); selv[0] = 3'd1;
    step(); selv[0] = 3'd2;
    @(negedge clk);
    check("bp_hold_x", odata[0], 32'h0000_00A1);
    check("bp_ready_low", 32'(irdy[0]), 32'd0);
    step();
    @(negedge clk); check("bp_still_x", odata[0], 32'h0000_00A1);
    ordy[0] = 1'b1;
    step();
    @(negedge clk);
    check("bp_y", odata[0], 32'h0000_00B2);
    check("bp_ready_back", 32'(irdy[0]), 32'd1);
    step(); inv[0] = 1'b0;
    @(negedge clk); check("bp_z", odata[0], 32'h0000_00C3);
    step();

    // Reset with skid full and output valid.
    ordy[0] = 1'b0; inv[0] = 1'b1; selv[0] = 3'd0;
    step(); step(); inv[0] = 1'b0;
    @(negedge clk); check("pre_rst_full", 32'(irdy[0]), 32'd0);
    rst = 1'b1; inv[0] = 1'b1; ordy[0] = 1'b1;
    step(); rst = 1'b0; selv[0] = 3'd1;
    @(negedge clk);
    check("mid_rst_valid", 32'(ov[0]), 32'd0);
    check("mid_rst_ready", 32'(irdy[0]), 32'd1);
    check("mid_rst_cnt", 32'(ecnt[0]), 32'd0);
    step(); inv[0] = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(ov[0]), 32'd1);
    check("post_rst_data", odata[0], 32'h0000_00B2);

    // Random traffic on all three configurations.
    for (int d = 0; d < 3; d++) nacc[d] = 0;
    cyc = 0;
    while ((nacc[1] < 10000 || nacc[2] < 10000) && cyc < 60000) begin
      step();
      cyc++;
      for (int d = 0; d < 3; d++) begin
        inv[d]  = 1'($urandom_range(0, 1));
        ordy[d] = 1'($urandom_range(0, 1));
        selv[d] = 3'($urandom_range(0, smask[d]));
        for (int k = 0; k < 5; k++) opnd[d][k] = $urandom();
      end
    end
    check("rand_beats_done", 32'(nacc[1] >= 10000 && nacc[2] >= 10000), 32'd1);
    for (int d = 0; d < 3; d++) begin
      inv[d] = 1'b0;
      ordy[d] = 1'b1;
    end
    repeat (4) step();
    @(negedge clk);
    check("five_cnt_sat", 32'(ecnt[1]), 32'd255);
    check("four_no_err", 32'(ecnt[2]), 32'd0);
    check("drained", 32'(ov[1] | ov[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
